tl_ram_responder: RTL and testbench
===================================

TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 Parameter DEPTH, default 64, gives the number of 32-bit words held (power of two, 2..1024).
REQ-002 Parameter BASE, default 26'h0, gives the byte base address of the window (aligned to 4*DEPTH).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 auto_in_a_ready  output  1  A-channel accept.
REQ-006 auto_in_a_valid  input  1  A-channel request valid.
REQ-007 auto_in_a_bits_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get; all others unsupported.
REQ-008 auto_in_a_bits_param  input  3  ignored.
REQ-009 auto_in_a_bits_size  input  2  log2 bytes.
REQ-010 auto_in_a_bits_source  input  10  requester tag.
REQ-011 auto_in_a_bits_address  input  26  byte address.
REQ-012 auto_in_a_bits_mask  input  4  byte lanes.
REQ-013 auto_in_a_bits_data  input  32  write data.
REQ-014 auto_in_a_bits_corrupt  input  1  write data poisoned.
REQ-015 auto_in_d_ready  input  1  D-channel accept.
REQ-016 auto_in_d_valid  output  1  response valid.
REQ-017 auto_in_d_bits_opcode  output  3  0=AccessAck, 1=AccessAckData.
REQ-018 auto_in_d_bits_size  output  2  echoed request size.
REQ-019 auto_in_d_bits_source  output  10  echoed request source.
REQ-020 auto_in_d_bits_denied  output  1  request refused.
REQ-021 auto_in_d_bits_data  output  32  read data; 0 unless AccessAckData and not denied.

Function
REQ-022 The block SHALL hold one response register (d_full plus captured fields); A-fire = a_valid & a_ready; D-fire = d_valid & d_ready.
REQ-023 a_ready SHALL equal !d_full | d_ready (combinational; full throughput of one request per cycle).
REQ-024 On A-fire the response register SHALL load next edge; d_valid SHALL equal d_full; latency A-fire to d_valid is exactly 1 cycle.
REQ-025 d_full SHALL clear on D-fire without A-fire, set on A-fire, and stay set on simultaneous A-fire and D-fire.
REQ-026 While d_valid & !d_ready, all d_bits SHALL hold stable.
REQ-027 In-range means BASE <= address < BASE+4*DEPTH; word index = (address-BASE)[log2(DEPTH)+1:2]; address[1:0] ignored.
REQ-028 Denied SHALL be 1 when opcode is unsupported, address out of range, or size == 3.
REQ-029 Response opcode SHALL be 1 for Get, 0 for every other opcode including unsupported ones.
REQ-030 Put not denied and corrupt=0 SHALL write data byte lanes selected by mask at the A-fire edge; mask=0 writes nothing.
REQ-031 Put with corrupt=1 SHALL suppress the write and respond AccessAck with denied=0.
REQ-032 Get not denied SHALL capture the full addressed word at A-fire; mask and size SHALL not alter returned data.
REQ-033 A Get accepted the cycle after a Put to the same word SHALL return the written data (no hazard window).
REQ-034 Denied responses SHALL return data 0 and SHALL never modify storage.
REQ-035 Storage SHALL be a register array without reset; contents undefined until written.

Reset
REQ-036 Reset low SHALL immediately force d_full=0 (d_valid=0), and opcode/size/source/denied/data registers to 0; a_ready=1 one cycle after reset release.
REQ-037 Reset asserted mid-response SHALL drop the pending response; no A-fire or write SHALL occur while reset is low.

Verification
REQ-038 PutFull addr 0x10 data 0xDEADBEEF mask 0xF src 5, then Get addr 0x10 src 6 -> AccessAck src 5 denied 0, then AccessAckData src 6 data 0xDEADBEEF.
REQ-039 PutPartial addr 0x10 mask 0x2 data 0x0000AA00 after REQ-038 -> Get returns 0xDEADAAEF.
REQ-040 Hold d_ready=0 three cycles after Get -> d_valid high, bits stable, a_ready=0; raise d_ready with new a_valid -> back-to-back responses, no gap.
REQ-041 Get addr 0x100 (DEPTH=64), opcode 2 at addr 0, size 3 Get -> each AccessAck/AccessAckData with denied 1, data 0, storage unchanged.
REQ-042 Put corrupt=1 data 0x12345678 to addr 0x20 holding 0x0 -> AccessAck denied 0; Get returns 0x0.
REQ-043 Assert reset while d_valid=1 -> d_valid=0 asynchronously; after release a_ready=1 and no stale response appears.

Source files
------------

// File: rtl/tl_ram_responder.sv
// Single-beat TileLink-UL RAM slave: one registered D-channel response slot,
// byte-masked word storage, and denial of unsupported or out-of-window requests.
module tl_ram_responder #(
  parameter int unsigned DEPTH = 64,
  parameter logic [25:0] BASE  = 26'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [1:0]  auto_in_a_bits_size,
  input  logic [9:0]  auto_in_a_bits_source,
  input  logic [25:0] auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic [31:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_size,
  output logic [9:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_denied,
  output logic [31:0] auto_in_d_bits_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACK      = 3'd0,
    D_ACK_DATA = 3'd1
  } d_op_e;

  logic [31:0]   r_mem [DEPTH];

  logic          r_live;
  logic          r_d_full;
  d_op_e         r_d_opcode;
  logic [1:0]    r_d_size;
  logic [9:0]    r_d_source;
  logic          r_d_denied;
  logic [31:0]   r_d_data;

  logic          w_a_ready;
  logic          w_a_fire;
  logic          w_d_fire;
  logic          w_is_put;
  logic          w_is_get;
  logic          w_in_range;
  logic          w_denied;
  logic          w_write;
  logic          w_param_sink;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;
  logic [26:0]   w_addr_ext;
  logic [26:0]   w_lo;
  logic [26:0]   w_hi;

  // a_ready stays low for the first cycle after reset release so nothing is
  // accepted while reset is asserted or in the release cycle itself.
  assign w_a_ready = r_live & (~r_d_full | auto_in_d_ready);
  assign w_a_fire  = auto_in_a_valid & w_a_ready;
  assign w_d_fire  = r_d_full & auto_in_d_ready;

  // param carries no meaning here; folding it into a constant-zero term keeps it referenced.
  assign w_param_sink = &{1'b0, auto_in_a_bits_param};

  always_comb begin
    w_is_put   = (auto_in_a_bits_opcode == A_PUT_FULL) ||
                 (auto_in_a_bits_opcode == A_PUT_PARTIAL);
    w_is_get   = (auto_in_a_bits_opcode == A_GET);
    w_addr_ext = {1'b0, auto_in_a_bits_address};
    w_lo       = {1'b0, BASE};
    w_hi       = w_lo + 27'(4 * DEPTH);
    w_in_range = (w_addr_ext >= w_lo) && (w_addr_ext < w_hi);
    // BASE is window-aligned, so the offset's word bits equal the address bits.
    w_idx      = auto_in_a_bits_address[AW+1:2];
    w_rd_word  = r_mem[w_idx];
    w_denied   = ~(w_is_put | w_is_get) | ~w_in_range |
                 (auto_in_a_bits_size == 2'd3) | w_param_sink;
    w_write    = w_a_fire & w_is_put & ~w_denied & ~auto_in_a_bits_corrupt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_live     <= 1'b0;
      r_d_full   <= 1'b0;
      r_d_opcode <= D_ACK;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_denied <= 1'b0;
      r_d_data   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_a_fire) begin
        r_d_full   <= 1'b1;
        r_d_opcode <= w_is_get ? D_ACK_DATA : D_ACK;
        r_d_size   <= auto_in_a_bits_size;
        r_d_source <= auto_in_a_bits_source;
        r_d_denied <= w_denied;
        r_d_data   <= (w_is_get && !w_denied) ? w_rd_word : '0;
      end else if (w_d_fire) begin
        r_d_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (auto_in_a_bits_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
        end
      end
    end
  end

  assign auto_in_a_ready       = w_a_ready;
  assign auto_in_d_valid       = r_d_full;
  assign auto_in_d_bits_opcode = r_d_opcode;
  assign auto_in_d_bits_size   = r_d_size;
  assign auto_in_d_bits_source = r_d_source;
  assign auto_in_d_bits_denied = r_d_denied;
  assign auto_in_d_bits_data   = r_d_data;

endmodule

// File: tb/tb_tl_ram_responder.sv
// Directed bench for tl_ram_responder: each task drives a scenario and checks
// the registered D-channel response against hand-computed values.
module tb_tl_ram_responder;

  logic        clock;
  logic        reset;
  logic        auto_in_a_ready;
  logic        auto_in_a_valid;
  logic [2:0]  auto_in_a_bits_opcode;
  logic [2:0]  auto_in_a_bits_param;
  logic [1:0]  auto_in_a_bits_size;
  logic [9:0]  auto_in_a_bits_source;
  logic [25:0] auto_in_a_bits_address;
  logic [3:0]  auto_in_a_bits_mask;
  logic [31:0] auto_in_a_bits_data;
  logic        auto_in_a_bits_corrupt;
  logic        auto_in_d_ready;
  logic        auto_in_d_valid;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_size;
  logic [9:0]  auto_in_d_bits_source;
  logic        auto_in_d_bits_denied;
  logic [31:0] auto_in_d_bits_data;

  int checks = 0;
  int errors = 0;

  tl_ram_responder #(.DEPTH(64), .BASE(26'h0)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_ready        (auto_in_a_ready),
    .auto_in_a_valid        (auto_in_a_valid),
    .auto_in_a_bits_opcode  (auto_in_a_bits_opcode),
    .auto_in_a_bits_param   (auto_in_a_bits_param),
    .auto_in_a_bits_size    (auto_in_a_bits_size),
    .auto_in_a_bits_source  (auto_in_a_bits_source),
    .auto_in_a_bits_address (auto_in_a_bits_address),
    .auto_in_a_bits_mask    (auto_in_a_bits_mask),
    .auto_in_a_bits_data    (auto_in_a_bits_data),
    .auto_in_a_bits_corrupt (auto_in_a_bits_corrupt),
    .auto_in_d_ready        (auto_in_d_ready),
    .auto_in_d_valid        (auto_in_d_valid),
    .auto_in_d_bits_opcode  (auto_in_d_bits_opcode),
    .auto_in_d_bits_size    (auto_in_d_bits_size),
    .auto_in_d_bits_source  (auto_in_d_bits_source),
    .auto_in_d_bits_denied  (auto_in_d_bits_denied),
    .auto_in_d_bits_data    (auto_in_d_bits_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one request and advance one edge; called at posedge+1 with d_ready high.
  task automatic issue(input logic [2:0] op, input logic [25:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [9:0] src, input logic [1:0] size,
                       input logic corrupt);
    auto_in_a_bits_opcode  = op;
    auto_in_a_bits_param   = 3'd0;
    auto_in_a_bits_address = addr;
    auto_in_a_bits_data    = data;
    auto_in_a_bits_mask    = mask;
    auto_in_a_bits_source  = src;
    auto_in_a_bits_size    = size;
    auto_in_a_bits_corrupt = corrupt;
    auto_in_a_valid        = 1'b1;
    @(posedge clock); #1;
    auto_in_a_valid        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; auto_in_a_valid = 1'b0; auto_in_d_ready = 1'b1;
    auto_in_a_bits_opcode = '0; auto_in_a_bits_param = '0; auto_in_a_bits_size = '0;
    auto_in_a_bits_source = '0; auto_in_a_bits_address = '0; auto_in_a_bits_mask = '0;
    auto_in_a_bits_data = '0; auto_in_a_bits_corrupt = 1'b0;
    #1;
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid got=%0h exp=0", auto_in_d_valid); end
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL rst_opcode got=%0h exp=0", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_size !== 2'd0) begin errors++; $display("FAIL rst_size got=%0h exp=0", auto_in_d_bits_size); end
    checks++; if (auto_in_d_bits_source !== 10'd0) begin errors++; $display("FAIL rst_source got=%0h exp=0", auto_in_d_bits_source); end
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL rst_denied got=%0h exp=0", auto_in_d_bits_denied); end
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%0h exp=0", auto_in_d_bits_data); end
    checks++; if (auto_in_a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready_low got=%0h exp=0", auto_in_a_ready); end
    #19 reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (auto_in_a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready_rel got=%0h exp=1", auto_in_a_ready); end
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid_rel got=%0h exp=0", auto_in_d_valid); end
  endtask

  task automatic test_put_get();
    issue(3'd0, 26'h10, 32'hDEADBEEF, 4'hF, 10'd5, 2'd2, 1'b0);
    checks++; if (auto_in_d_valid !== 1'b1) begin errors++; $display("FAIL put_valid got=%0h exp=1", auto_in_d_valid); end
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL put_opcode got=%0h exp=0", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_source !== 10'd5) begin errors++; $display("FAIL put_source got=%0h exp=5", auto_in_d_bits_source); end
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL put_denied got=%0h exp=0", auto_in_d_bits_denied); end
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL put_data got=%0h exp=0", auto_in_d_bits_data); end
    checks++; if (auto_in_d_bits_size !== 2'd2) begin errors++; $display("FAIL put_size got=%0h exp=2", auto_in_d_bits_size); end
    issue(3'd4, 26'h10, 32'h0, 4'hF, 10'd6, 2'd2, 1'b0);
    checks++; if (auto_in_d_valid !== 1'b1) begin errors++; $display("FAIL get_valid got=%0h exp=1", auto_in_d_valid); end
    checks++; if (auto_in_d_bits_opcode !== 3'd1) begin errors++; $display("FAIL get_opcode got=%0h exp=1", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_source !== 10'd6) begin errors++; $display("FAIL get_source got=%0h exp=6", auto_in_d_bits_source); end
    checks++; if (auto_in_d_bits_data !== 32'hDEADBEEF) begin errors++; $display("FAIL get_data got=%0h exp=deadbeef", auto_in_d_bits_data); end
  endtask

  task automatic test_partial();
    issue(3'd1, 26'h10, 32'h0000AA00, 4'h2, 10'd10, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL part_opcode got=%0h exp=0", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL part_denied got=%0h exp=0", auto_in_d_bits_denied); end
    // Unaligned address, zero mask and byte size must still return the whole word.
    issue(3'd4, 26'h13, 32'h0, 4'h0, 10'd11, 2'd0, 1'b0);
    checks++; if (auto_in_d_bits_data !== 32'hDEADAAEF) begin errors++; $display("FAIL part_data got=%0h exp=deadaaef", auto_in_d_bits_data); end
    checks++; if (auto_in_d_bits_size !== 2'd0) begin errors++; $display("FAIL part_size got=%0h exp=0", auto_in_d_bits_size); end
    checks++; if (auto_in_d_bits_source !== 10'd11) begin errors++; $display("FAIL part_source got=%0h exp=b", auto_in_d_bits_source); end
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1;
    auto_in_d_ready = 1'b0;
    issue(3'd4, 26'h10, 32'h0, 4'hF, 10'd7, 2'd2, 1'b0);
    auto_in_a_bits_source = 10'd8;
    auto_in_a_valid       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (auto_in_d_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0h exp=1", i, auto_in_d_valid); end
      checks++; if (auto_in_d_bits_source !== 10'd7) begin errors++; $display("FAIL bp_source[%0d] got=%0h exp=7", i, auto_in_d_bits_source); end
      checks++; if (auto_in_d_bits_data !== 32'hDEADAAEF) begin errors++; $display("FAIL bp_data[%0d] got=%0h exp=deadaaef", i, auto_in_d_bits_data); end
      checks++; if (auto_in_a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready[%0d] got=%0h exp=0", i, auto_in_a_ready); end
      @(posedge clock); #1;
    end
    auto_in_d_ready = 1'b1;
    #1;
    checks++; if (auto_in_a_ready !== 1'b1) begin errors++; $display("FAIL bp_a_ready_rel got=%0h exp=1", auto_in_a_ready); end
    @(posedge clock); #1;
    checks++; if (auto_in_d_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got=%0h exp=1", auto_in_d_valid); end
    checks++; if (auto_in_d_bits_source !== 10'd8) begin errors++; $display("FAIL b2b_source0 got=%0h exp=8", auto_in_d_bits_source); end
    auto_in_a_bits_opcode = 3'd0; auto_in_a_bits_address = 26'h14;
    auto_in_a_bits_data = 32'h01020304; auto_in_a_bits_source = 10'd9;
    @(posedge clock); #1;
    checks++; if (auto_in_d_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got=%0h exp=1", auto_in_d_valid); end
    checks++; if (auto_in_d_bits_source !== 10'd9) begin errors++; $display("FAIL b2b_source1 got=%0h exp=9", auto_in_d_bits_source); end
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL b2b_opcode1 got=%0h exp=0", auto_in_d_bits_opcode); end
    auto_in_a_valid = 1'b0;
    @(posedge clock); #1;
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0h exp=0", auto_in_d_valid); end
  endtask

  task automatic test_denied();
    issue(3'd0, 26'h0, 32'hCAFEF00D, 4'hF, 10'd20, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL den_seed got=%0h exp=0", auto_in_d_bits_denied); end
    issue(3'd4, 26'h100, 32'h0, 4'hF, 10'd21, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b1) begin errors++; $display("FAIL den_oor_get got=%0h exp=1", auto_in_d_bits_denied); end
    checks++; if (auto_in_d_bits_opcode !== 3'd1) begin errors++; $display("FAIL den_oor_get_op got=%0h exp=1", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL den_oor_get_data got=%0h exp=0", auto_in_d_bits_data); end
    issue(3'd0, 26'h100, 32'h11111111, 4'hF, 10'd22, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b1) begin errors++; $display("FAIL den_oor_put got=%0h exp=1", auto_in_d_bits_denied); end
    issue(3'd2, 26'h0, 32'h55555555, 4'hF, 10'd23, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b1) begin errors++; $display("FAIL den_op2 got=%0h exp=1", auto_in_d_bits_denied); end
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL den_op2_op got=%0h exp=0", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL den_op2_data got=%0h exp=0", auto_in_d_bits_data); end
    issue(3'd4, 26'h10, 32'h0, 4'hF, 10'd24, 2'd3, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b1) begin errors++; $display("FAIL den_size3 got=%0h exp=1", auto_in_d_bits_denied); end
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL den_size3_data got=%0h exp=0", auto_in_d_bits_data); end
    checks++; if (auto_in_d_bits_size !== 2'd3) begin errors++; $display("FAIL den_size3_size got=%0h exp=3", auto_in_d_bits_size); end
    issue(3'd0, 26'h0, 32'h77777777, 4'hF, 10'd25, 2'd3, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b1) begin errors++; $display("FAIL den_size3_put got=%0h exp=1", auto_in_d_bits_denied); end
    issue(3'd4, 26'h0, 32'h0, 4'hF, 10'd26, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_data !== 32'hCAFEF00D) begin errors++; $display("FAIL den_unchanged got=%0h exp=cafef00d", auto_in_d_bits_data); end
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL den_unchanged_den got=%0h exp=0", auto_in_d_bits_denied); end
    issue(3'd0, 26'hFC, 32'hA5A5A5A5, 4'hF, 10'd27, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL den_top_put got=%0h exp=0", auto_in_d_bits_denied); end
    issue(3'd4, 26'hFC, 32'h0, 4'hF, 10'd28, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL den_top_get got=%0h exp=a5a5a5a5", auto_in_d_bits_data); end
  endtask

  task automatic test_corrupt();
    issue(3'd0, 26'h20, 32'h0, 4'hF, 10'd30, 2'd2, 1'b0);
    issue(3'd0, 26'h20, 32'h12345678, 4'hF, 10'd31, 2'd2, 1'b1);
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL cor_opcode got=%0h exp=0", auto_in_d_bits_opcode); end
    checks++; if (auto_in_d_bits_denied !== 1'b0) begin errors++; $display("FAIL cor_denied got=%0h exp=0", auto_in_d_bits_denied); end
    checks++; if (auto_in_d_bits_source !== 10'd31) begin errors++; $display("FAIL cor_source got=%0h exp=1f", auto_in_d_bits_source); end
    issue(3'd4, 26'h20, 32'h0, 4'hF, 10'd32, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL cor_get got=%0h exp=0", auto_in_d_bits_data); end
    issue(3'd1, 26'h20, 32'hFFFFFFFF, 4'h0, 10'd33, 2'd2, 1'b0);
    issue(3'd4, 26'h20, 32'h0, 4'hF, 10'd34, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL mask0_get got=%0h exp=0", auto_in_d_bits_data); end
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 26'h10, 32'h0, 4'hF, 10'd40, 2'd2, 1'b0);
    auto_in_d_ready = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL rmid_d_valid got=%0h exp=0", auto_in_d_valid); end
    checks++; if (auto_in_d_bits_data !== 32'h0) begin errors++; $display("FAIL rmid_data got=%0h exp=0", auto_in_d_bits_data); end
    checks++; if (auto_in_d_bits_source !== 10'd0) begin errors++; $display("FAIL rmid_source got=%0h exp=0", auto_in_d_bits_source); end
    checks++; if (auto_in_d_bits_opcode !== 3'd0) begin errors++; $display("FAIL rmid_opcode got=%0h exp=0", auto_in_d_bits_opcode); end
    auto_in_a_bits_opcode = 3'd0; auto_in_a_bits_address = 26'h10; auto_in_a_bits_data = 32'hBAD0BAD0;
    auto_in_a_bits_mask = 4'hF; auto_in_a_bits_source = 10'd41; auto_in_a_bits_size = 2'd2;
    auto_in_a_bits_corrupt = 1'b0; auto_in_a_valid = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    checks++; if (auto_in_a_ready !== 1'b0) begin errors++; $display("FAIL rmid_a_ready got=%0h exp=0", auto_in_a_ready); end
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL rmid_held_valid got=%0h exp=0", auto_in_d_valid); end
    auto_in_a_valid = 1'b0; auto_in_d_ready = 1'b1;
    #2 reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (auto_in_a_ready !== 1'b1) begin errors++; $display("FAIL rmid_a_ready_rel got=%0h exp=1", auto_in_a_ready); end
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale0 got=%0h exp=0", auto_in_d_valid); end
    @(posedge clock); #1;
    checks++; if (auto_in_d_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale1 got=%0h exp=0", auto_in_d_valid); end
    issue(3'd4, 26'h10, 32'h0, 4'hF, 10'd42, 2'd2, 1'b0);
    checks++; if (auto_in_d_bits_data !== 32'hDEADAAEF) begin errors++; $display("FAIL rmid_no_write got=%0h exp=deadaaef", auto_in_d_bits_data); end
    checks++; if (auto_in_d_bits_source !== 10'd42) begin errors++; $display("FAIL rmid_source_after got=%0h exp=2a", auto_in_d_bits_source); end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_back_to_back();
    test_denied();
    test_corrupt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
